uart_byte_tx: RTL

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_byte_tx_if.sv | 19 +
 rtl/uart_baud_tick.sv | 46 ++++
 rtl/uart_byte_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, baud divisor lookup and transmitter state encoding.
// UART_TX_TWO_STOP_EN adds the second stop-bit state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BAUD_SEL_W = 3;

  localparam int unsigned DR_9600   = 324;
  localparam int unsigned DR_19200  = 162;
  localparam int unsigned DR_38400  = 80;
  localparam int unsigned DR_57600  = 53;
  localparam int unsigned DR_115200 = 26;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
`ifdef UART_TX_TWO_STOP_EN
    ,
    TX_STOP2 = 3'd4
`endif
  } tx_state_e;

  // Unused select codes fall back to the slowest rate.
  function automatic int unsigned baud_div(input logic [BAUD_SEL_W-1:0] sel);
    case (sel)
      3'd1:    return DR_19200;
      3'd2:    return DR_38400;
      3'd3:    return DR_57600;
      3'd4:    return DR_115200;
      default: return DR_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Request/serial-line bundle between a byte source and the UART transmitter.
interface uart_byte_tx_if;
  logic [2:0] baud_set;
  logic       send_en;
  logic [7:0] data_byte;
  logic       uart_tx;
  logic       tx_done;
  logic       uart_state;

  modport master (
    output baud_set, send_en, data_byte,
    input  uart_tx, tx_done, uart_state
  );

  modport slave (
    input  baud_set, send_en, data_byte,
    output uart_tx, tx_done, uart_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Baud divider: a tick every dr_i+1 clocks, a bit-end strobe every OVERSAMPLE ticks.
// Both counters sit at zero while disabled so a new frame starts phase-aligned.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] dr_i,
  output logic             tick_c_o,
  output logic             bit_end_c_o
);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  always_comb begin
    div_d       = '0;
    tick_d      = '0;
    tick_c_o    = en_i && (div_q == dr_i);
    bit_end_c_o = tick_c_o && (tick_q == TICK_W'(OVERSAMPLE - 1));
    if (en_i) begin
      div_d = tick_c_o ? '0 : div_q + DIV_W'(1);
      if (bit_end_c_o) begin
        tick_d = '0;
      end else if (tick_c_o) begin
        tick_d = tick_q + TICK_W'(1);
      end else begin
        tick_d = tick_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 frames (8N2 with UART_TX_TWO_STOP_EN), LSB first,
// 16x-oversampled bit timing shared with the receiver's divider.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_byte_tx_if.slave  bus
);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]  dr_q, dr_d;
  logic              uart_tx_q, uart_tx_d;
  logic              tx_done_q, tx_done_d;
  logic              busy_q, busy_d;
  logic              tick_c;
  logic              bit_end_c;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (state_q != TX_IDLE),
    .dr_i       (dr_q),
    .tick_c_o   (tick_c),
    .bit_end_c_o(bit_end_c)
  );

  // Next state; the line level is derived from the next state so uart_tx stays registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    dr_d      = dr_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    uart_tx_d = 1'b1;

    unique case (state_q)
      TX_IDLE: begin
        if (bus.send_en) begin
          shift_d   = bus.data_byte;
          dr_d      = DIV_W'(baud_div(bus.baud_set));
          bit_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (bit_end_c) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end_c) begin
          shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (bit_end_c) begin
`ifdef UART_TX_TWO_STOP_EN
          state_d = TX_STOP2;
`else
          state_d   = TX_IDLE;
          busy_d    = 1'b0;
          tx_done_d = 1'b1;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_EN
      TX_STOP2: begin
        if (bit_end_c) begin
          state_d   = TX_IDLE;
          busy_d    = 1'b0;
          tx_done_d = 1'b1;
        end
      end
`endif
      default: state_d = TX_IDLE;
    endcase

    if (state_d == TX_START) begin
      uart_tx_d = 1'b0;
    end else if (state_d == TX_DATA) begin
      uart_tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      dr_q      <= DIV_W'(DR_9600);
      uart_tx_q <= 1'b1;
      tx_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      dr_q      <= dr_d;
      uart_tx_q <= uart_tx_d;
      tx_done_q <= tx_done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.uart_tx    = uart_tx_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.uart_state = busy_q;

  logic unused_tick;
  assign unused_tick = tick_c;

endmodule
